// File: rtl/leaf_sched_pkg.sv
// Shared types and default sizing for the leaf grant scheduler.
package leaf_sched_pkg;

  localparam int N_REQ_DEF    = 10;
  localparam int HOLD_MAX_DEF = 16;
  localparam int IDX_W        = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/leaf_rr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping to 0.
module leaf_rr_pick
  import leaf_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_win_oh,
  output logic [$clog2(N_REQ)-1:0] o_win_id,
  output logic                     o_any
);

  localparam int          IW = $clog2(N_REQ);
  localparam int unsigned NU = N_REQ;

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_win_oh = '0;
    o_win_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      w_idx = IW'((32'(i_ptr) + i) % NU);
      if (!w_found && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_win_oh[w_idx]  = 1'b1;
        o_win_id         = w_idx;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/leaf_grant_scheduler.sv
// Round-robin single-grant scheduler with one-cycle release gap.
// Optional forced release after HOLD_MAX cycles: define LEAF_SCHED_TIMEOUT_EN.
module leaf_grant_scheduler
  import leaf_sched_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);

  sched_state_t   r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]    r_gnt_id, w_id_nxt;
  logic [IW-1:0]    r_ptr, w_ptr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_timeout, w_to_nxt;

  logic [N_REQ-1:0] w_win_oh;
  logic [IW-1:0]    w_win_id;
  logic             w_any;
  logic             w_rel_req;
  logic             w_hold_exp;

  leaf_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_win_oh (w_win_oh),
    .o_win_id (w_win_id),
    .o_any    (w_any)
  );

  // A dropped request from the granted leaf releases exactly like done.
  assign w_rel_req = done || ((req & r_gnt) == '0);

`ifdef LEAF_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || w_state_nxt != GRANT) r_cnt <= '0;
    else if (r_state == GRANT)          r_cnt <= r_cnt + 1'b1;
    else                                r_cnt <= CW'(1);
  end

  assign w_hold_exp = (r_cnt == CW'(HOLD_MAX));
`else
  logic w_unused_hold;
  assign w_unused_hold = (HOLD_MAX > 0);
  assign w_hold_exp    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_gnt_id;
    w_busy_nxt  = r_busy;
    w_ptr_nxt   = r_ptr;
    w_to_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_win_oh;
          w_id_nxt    = w_win_id;
          w_busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (w_rel_req || w_hold_exp) begin
          w_state_nxt = RELEASE;
          w_gnt_nxt   = '0;
          w_id_nxt    = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = (r_gnt_id == IW'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
          w_to_nxt    = !w_rel_req;
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_busy    <= 1'b0;
      r_ptr     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_id_nxt;
      r_busy    <= w_busy_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timeout <= w_to_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_leaf_grant_scheduler.sv
// Directed bench for leaf_grant_scheduler; timeout cases follow LEAF_SCHED_TIMEOUT_EN.
module tb_leaf_grant_scheduler;

  localparam int N  = 10;
  localparam int HM = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [3:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  leaf_grant_scheduler #(.N_REQ(N), .HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [N-1:0] exp_g;
    logic         hold_ok;

    rst_n = 1'b0; req = '0; done = 1'b0;
    cyc(); cyc();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);

    // single request on leaf 3
    rst_n = 1'b1; req = 10'b0000001000;
    cyc();
    chk("g3_gnt", 32'(gnt), 32'h008);
    chk("g3_id", 32'(gnt_id), 32'd3);
    chk("g3_busy", 32'(busy), 32'h1);
    req = 10'b0000001011;
    cyc();
    chk("g3_hold", 32'(gnt), 32'h008);
    done = 1'b1;
    cyc();
    chk("g3_rel_gnt", 32'(gnt), 32'h0);
    chk("g3_rel_busy", 32'(busy), 32'h0);
    done = 1'b0; req = 10'b0000011001;
    cyc();
    chk("g3_idle_gnt", 32'(gnt), 32'h0);
    cyc();
    chk("ptr4_id", 32'(gnt_id), 32'd4);
    done = 1'b1; req = '0;
    cyc();
    done = 1'b0;
    cyc();

    // full contention: order 0..9 then wrap to 0
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; req = '1;
    for (int k = 0; k <= 10; k++) begin
      exp_g = '0;
      exp_g[k % 10] = 1'b1;
      cyc();
      chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(exp_g));
      chk($sformatf("rr_id%0d", k), 32'(gnt_id), 32'(k % 10));
      done = 1'b1;
      cyc();
      chk($sformatf("rr_rel%0d", k), 32'(gnt), 32'h0);
      done = 1'b0;
      cyc();
    end
    req = '0;
    cyc(); cyc();

    // granted leaf drops its request without done
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; req = 10'b0000000100;
    cyc();
    chk("drop_gnt", 32'(gnt), 32'h004);
    req = '0;
    cyc();
    chk("drop_rel_gnt", 32'(gnt), 32'h0);
    chk("drop_rel_busy", 32'(busy), 32'h0);
    chk("drop_rel_to", 32'(timeout), 32'h0);
    req = 10'b0000001101;
    cyc();
    cyc();
    chk("ptr3_id", 32'(gnt_id), 32'd3);
    done = 1'b1; req = '0;
    cyc();
    done = 1'b0;
    cyc();

    // reset while leaf 7 is granted
    req = 10'b0010000000;
    cyc();
    chk("g7_gnt", 32'(gnt), 32'h080);
    rst_n = 1'b0;
    cyc();
    chk("rstmid_gnt", 32'(gnt), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_to", 32'(timeout), 32'h0);
    rst_n = 1'b1; req = 10'b1000000001;
    cyc();
    chk("rstmid_ptr0", 32'(gnt_id), 32'd0);
    done = 1'b1; req = '0;
    cyc();
    done = 1'b0;
    cyc();

`ifdef LEAF_SCHED_TIMEOUT_EN
    // leaf 5 held without done: forced release after HM cycles
    req = 10'b0001100000;
    cyc();
    chk("to_g5", 32'(gnt), 32'h020);
    hold_ok = 1'b1;
    for (int c = 0; c < HM - 1; c++) begin
      cyc();
      if (gnt !== 10'b0000100000 || timeout !== 1'b0) hold_ok = 1'b0;
    end
    chk("to_hold16", 32'(hold_ok), 32'h1);
    cyc();
    chk("to_rel_gnt", 32'(gnt), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    cyc();
    chk("to_pulse_end", 32'(timeout), 32'h0);
    cyc();
    chk("to_next_g6", 32'(gnt), 32'h040);
    // done coincides with the final hold cycle
    for (int c = 0; c < HM - 1; c++) cyc();
    done = 1'b1;
    cyc();
    chk("tod_rel_gnt", 32'(gnt), 32'h0);
    chk("tod_no_pulse", 32'(timeout), 32'h0);
    done = 1'b0; req = '0;
    cyc(); cyc();
`else
    // without the timeout option the grant is held indefinitely
    req = 10'b0000100000;
    cyc();
    chk("nto_g5", 32'(gnt), 32'h020);
    hold_ok = 1'b1;
    for (int c = 0; c < HM + 8; c++) begin
      cyc();
      if (gnt !== 10'b0000100000 || timeout !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
    end
    chk("nto_hold", 32'(hold_ok), 32'h1);
    done = 1'b1;
    cyc();
    chk("nto_rel_gnt", 32'(gnt), 32'h0);
    chk("nto_rel_to", 32'(timeout), 32'h0);
    done = 1'b0; req = '0;
    cyc(); cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
